// File: rtl/sc_udc_accum_pkg.sv
// sc_pkg: shared stochastic-compute types and limits.
// Holds the UDC FSM state type, the default widths, and the clamp helpers.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DRAIN = 2'd2
  } udc_state_e;

  localparam int SC_ACC_W   = 8;
  localparam int SC_OUT_W   = 4;
  localparam int SC_ACC_MAX = 2**(SC_ACC_W-1) - 1;
  localparam int SC_ACC_MIN = -(2**(SC_ACC_W-1));

  function automatic int sc_clamp(
    input int v,
    input int lo,
    input int hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sc_clip(
    input int v,
    input int lo,
    input int hi
  );
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/sc_udc_accum_lane.sv
// sc_sat_udc_lane: one saturating signed up/down counter.
// Ports: clk/rst (async high), en (count), clr (start from 0),
// sn_bit (1=+1, 0=-1), acc (signed count), sat (sticky saturation).
module sc_sat_udc_lane
  import sc_pkg::*;
#(
  parameter int ACC_W = SC_ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    sn_bit,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] AMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ONE =
    ACC_W'(1);

  logic signed [ACC_W-1:0] base;
  logic                    hit;
  logic                    sat_base;

  // clr replaces the old count with 0 in the same cycle
  // as the first bit, so the entry cycle still counts.
  always_comb begin
    base     = clr ? '0 : acc;
    sat_base = clr ? 1'b0 : sat;
    hit      = sn_bit ? (base == AMAX) : (base == AMIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (hit)
        acc <= base;
      else if (sn_bit)
        acc <= base + ONE;
      else
        acc <= base - ONE;
      sat <= sat_base | hit;
    end
  end

endmodule

// File: rtl/sc_udc_accum.sv
// sc_udc_accum: per-lane SN up/down integrator with clamped valid/ready output.
// In: i_clk_udc, i_rst_udc, i_start_udc, i_clr_udc, i_sn_bit_udc, i_ready_udc.
// Out: o_valid_udc, o_busy_udc, o_acc_udc, o_sat_udc, o_ovr_udc.
module sc_udc_accum
  import sc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int ACC_W = SC_ACC_W,
  parameter int OUT_W = SC_OUT_W
) (
  input  logic                   i_clk_udc,
  input  logic                   i_rst_udc,
  input  logic                   i_start_udc,
  input  logic                   i_clr_udc,
  input  logic [LANES-1:0]       i_sn_bit_udc,
  input  logic                   i_ready_udc,
  output logic                   o_valid_udc,
  output logic                   o_busy_udc,
  output logic [LANES*OUT_W-1:0] o_acc_udc,
  output logic [LANES-1:0]       o_sat_udc,
  output logic                   o_ovr_udc
);

  localparam int OMAX = 2**(OUT_W-1) - 1;
  localparam int OMIN = -(2**(OUT_W-1));

  udc_state_e state;

  logic signed [ACC_W-1:0] acc [LANES];
  logic [LANES-1:0]        lane_sat;
  logic [LANES-1:0]        clip;
  logic [LANES-1:0]        csat;
  logic [LANES-1:0]        sat_q;
  logic [LANES*OUT_W-1:0]  acc_d;
  logic [LANES*OUT_W-1:0]  acc_q;
  logic                    valid_q;
  logic                    ovr_q;
  logic                    cnt_en;
  logic                    cnt_clr;

  // Bits arriving in DRAIN are dropped; they only flag overrun.
  assign cnt_en  = i_start_udc && (state != DRAIN);
  assign cnt_clr = (state == IDLE) && i_clr_udc;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sc_sat_udc_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (i_clk_udc),
      .rst    (i_rst_udc),
      .en     (cnt_en),
      .clr    (cnt_clr),
      .sn_bit (i_sn_bit_udc[k]),
      .acc    (acc[k]),
      .sat    (lane_sat[k])
    );
  end

  always_comb begin
    acc_d = '0;
    clip  = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_d[k*OUT_W +: OUT_W] =
        OUT_W'(sc_clamp(int'(acc[k]), OMIN, OMAX));
      clip[k] = sc_clip(int'(acc[k]), OMIN, OMAX);
    end
  end

  // csat remembers output-clamp hits so that, like the
  // counter flags, they survive windows chained without clr.
  always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
    if (i_rst_udc) begin
      state   <= IDLE;
      acc_q   <= '0;
      sat_q   <= '0;
      csat    <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start_udc) begin
            state <= COUNT;
            if (i_clr_udc)
              csat <= '0;
          end
        end
        COUNT: begin
          if (!i_start_udc) begin
            state   <= DRAIN;
            acc_q   <= acc_d;
            sat_q   <= lane_sat | csat | clip;
            csat    <= csat | clip;
            valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (i_start_udc)
            ovr_q <= 1'b1;
          if (i_ready_udc) begin
            valid_q <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valid_udc = valid_q;
  assign o_busy_udc  = (state != IDLE);
  assign o_acc_udc   = acc_q;
  assign o_sat_udc   = sat_q;
  assign o_ovr_udc   = ovr_q;

endmodule

// File: tb/tb_sc_udc_accum.sv
// tb_sc_udc_accum: directed + random windows on two instances
// (ACC_W=8 and ACC_W=4) against an arithmetic reference model.
module tb_sc_udc_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clr;
  logic        ready;
  logic [3:0]  sn;

  logic        v8, b8, ov8;
  logic [15:0] a8;
  logic [3:0]  s8;
  logic        v4, b4, ov4;
  logic [15:0] a4;
  logic [3:0]  s4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  pat [64];
  int          m_acc [2][4];
  bit          m_sat [2][4];
  logic [15:0] m_out [2];
  logic [3:0]  m_osat [2];
  bit          m_ovr;

  always #5 clk = ~clk;

  sc_udc_accum #(.LANES(4), .ACC_W(8), .OUT_W(4)) dut8 (
    .i_clk_udc    (clk),
    .i_rst_udc    (rst),
    .i_start_udc  (start),
    .i_clr_udc    (clr),
    .i_sn_bit_udc (sn),
    .i_ready_udc  (ready),
    .o_valid_udc  (v8),
    .o_busy_udc   (b8),
    .o_acc_udc    (a8),
    .o_sat_udc    (s8),
    .o_ovr_udc    (ov8)
  );

  sc_udc_accum #(.LANES(4), .ACC_W(4), .OUT_W(4)) dut4 (
    .i_clk_udc    (clk),
    .i_rst_udc    (rst),
    .i_start_udc  (start),
    .i_clr_udc    (clr),
    .i_sn_bit_udc (sn),
    .i_ready_udc  (ready),
    .o_valid_udc  (v4),
    .o_busy_udc   (b4),
    .o_acc_udc    (a4),
    .o_sat_udc    (s4),
    .o_ovr_udc    (ov4)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int amax(input int i);
    return (i == 0) ? 127 : 7;
  endfunction

  function automatic int amin(input int i);
    return (i == 0) ? -128 : -8;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[i][k] = 0;
        m_sat[i][k] = 1'b0;
      end
      m_out[i]  = '0;
      m_osat[i] = '0;
    end
    m_ovr = 1'b0;
  endfunction

  function automatic void model_start(input bit c);
    if (c)
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) begin
          m_acc[i][k] = 0;
          m_sat[i][k] = 1'b0;
        end
  endfunction

  function automatic void model_count(input logic [3:0] b);
    int n;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        n = m_acc[i][k] + (b[k] ? 1 : -1);
        if (n > amax(i)) begin
          n = amax(i);
          m_sat[i][k] = 1'b1;
        end else if (n < amin(i)) begin
          n = amin(i);
          m_sat[i][k] = 1'b1;
        end
        m_acc[i][k] = n;
      end
  endfunction

  function automatic void model_end();
    int v;
    logic [31:0] t;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) begin
        v = m_acc[i][k];
        if (v > 7) begin
          v = 7;
          m_sat[i][k] = 1'b1;
        end else if (v < -8) begin
          v = -8;
          m_sat[i][k] = 1'b1;
        end
        t = v;
        m_out[i][k*4 +: 4] = t[3:0];
        m_osat[i][k] = m_sat[i][k];
      end
  endfunction

  task automatic check_all(
    input string tag,
    input bit    ev,
    input bit    eb
  );
    check({tag, "/valid8"}, 32'(v8), 32'(ev));
    check({tag, "/busy8"},  32'(b8), 32'(eb));
    check({tag, "/acc8"},   32'(a8), 32'(m_out[0]));
    check({tag, "/sat8"},   32'(s8), 32'(m_osat[0]));
    check({tag, "/ovr8"},   32'(ov8), 32'(m_ovr));
    check({tag, "/valid4"}, 32'(v4), 32'(ev));
    check({tag, "/busy4"},  32'(b4), 32'(eb));
    check({tag, "/acc4"},   32'(a4), 32'(m_out[1]));
    check({tag, "/sat4"},   32'(s4), 32'(m_osat[1]));
    check({tag, "/ovr4"},   32'(ov4), 32'(m_ovr));
  endtask

  // Called at a negedge with the DUT idle (or just back from
  // a handshake with start held high). Leaves start high if ovl.
  task automatic run_window(
    input string tag,
    input bit    c,
    input int    len,
    input int    rdly,
    input bit    ovl
  );
    for (int j = 0; j < len; j++) begin
      start = 1'b1;
      clr   = (j == 0) ? c : 1'($urandom);
      sn    = pat[j];
      ready = 1'($urandom);
      if (j == 0)
        model_start(c);
      model_count(pat[j]);
      @(negedge clk);
      check_all({tag, "/cnt"}, 1'b0, 1'b1);
    end
    start = 1'b0;
    sn    = 4'($urandom);
    ready = 1'($urandom);
    @(negedge clk);
    model_end();
    check_all({tag, "/res"}, 1'b1, 1'b1);
    for (int j = 0; j < rdly; j++) begin
      ready = 1'b0;
      start = ovl;
      sn    = 4'($urandom);
      if (ovl)
        m_ovr = 1'b1;
      @(negedge clk);
      check_all({tag, "/hold"}, 1'b1, 1'b1);
    end
    ready = 1'b1;
    start = ovl;
    if (ovl)
      m_ovr = 1'b1;
    @(negedge clk);
    check_all({tag, "/hs"}, 1'b0, 1'b0);
    ready = 1'b0;
    start = ovl;
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    sn    = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int j = 0; j < 6; j++)
      pat[j] = {1'b1, (j % 2 == 0), 1'b0, 1'b1};
    run_window("t1", 1'b1, 6, 1, 1'b0);

    for (int j = 0; j < 20; j++)
      pat[j] = 4'hF;
    run_window("t2", 1'b1, 20, 5, 1'b0);

    for (int j = 0; j < 3; j++)
      pat[j] = 4'hF;
    run_window("t3a", 1'b1, 3, 0, 1'b0);
    for (int j = 0; j < 2; j++)
      pat[j] = 4'h0;
    run_window("t3b", 1'b0, 2, 0, 1'b0);

    for (int j = 0; j < 12; j++)
      pat[j] = 4'h0;
    run_window("t4a", 1'b1, 12, 1, 1'b0);
    pat[0] = 4'hF;
    run_window("t4b", 1'b0, 1, 0, 1'b0);

    for (int j = 0; j < 4; j++)
      pat[j] = 4'($urandom);
    run_window("t5a", 1'b1, 4, 2, 1'b1);
    for (int j = 0; j < 3; j++)
      pat[j] = 4'($urandom);
    run_window("t5b", 1'b0, 3, 0, 1'b0);

    start = 1'b1;
    clr   = 1'b1;
    model_start(1'b1);
    for (int j = 0; j < 3; j++) begin
      sn = 4'hF;
      model_count(4'hF);
      @(negedge clk);
      clr = 1'b0;
    end
    reset_pulse("t6cnt");
    for (int j = 0; j < 5; j++)
      pat[j] = 4'($urandom);
    run_window("t6a", 1'b0, 5, 1, 1'b0);

    start = 1'b1;
    clr   = 1'b1;
    model_start(1'b1);
    for (int j = 0; j < 4; j++) begin
      sn = 4'h5;
      model_count(4'h5);
      @(negedge clk);
      clr = 1'b0;
    end
    start = 1'b0;
    @(negedge clk);
    model_end();
    check_all("t6pre", 1'b1, 1'b1);
    reset_pulse("t6drn");
    for (int j = 0; j < 5; j++)
      pat[j] = 4'($urandom);
    run_window("t6b", 1'b0, 5, 0, 1'b0);

    for (int w = 0; w < 40; w++) begin
      int len;
      int rd;
      bit c;
      bit ov;
      logic [3:0] mode [4];
      len = $urandom_range(1, 24);
      rd  = $urandom_range(0, 4);
      c   = ($urandom % 3) != 0;
      ov  = (w != 39) && (($urandom % 4) == 0);
      for (int k = 0; k < 4; k++)
        mode[k] = 4'($urandom % 4);
      for (int j = 0; j < len; j++)
        for (int k = 0; k < 4; k++)
          pat[j][k] = (mode[k] == 0) ? 1'b1 :
                      (mode[k] == 1) ? 1'b0 :
                      1'($urandom);
      run_window("rnd", c, len, rd, ov);
      if (!ov) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          start = 1'b0;
          clr   = 1'($urandom);
          ready = 1'($urandom);
          sn    = 4'($urandom);
          @(negedge clk);
          check_all("idle", 1'b0, 1'b0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
